// File: rtl/reg_file_mp.sv
// reg_file_mp: register file with two write ports and three combinational read ports.
// After reset, a CLEAR sequence zeroes one register per cycle. busy stays high
// until every register has been zeroed. Address 0 always reads as zero.
// Optional macro REG_FILE_BYPASS_EN: when defined, a read of an address that is
// being written in the same cycle returns the incoming write data. When it is
// not defined, such a read returns the value stored before the write.
module reg_file_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we1,
    input  logic              we2,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [ADDR_W-1:0] wa2,
    input  logic [DATA_W-1:0] wd1,
    input  logic [DATA_W-1:0] wd2,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    input  logic [ADDR_W-1:0] ra3,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic [DATA_W-1:0] rd3,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    // The last register is all-ones because DEPTH is an exact power of two.
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   mem_d [DEPTH];

    logic                clr_en;
    logic                wr1_en;
    logic                wr2_en;
    logic [ADDR_W-1:0]   ra_v [3];
    logic [DATA_W-1:0]   rd_v [3];

    assign busy = (state_q == CLEAR);

    // User writes need: enable set, not busy, not in reset, and a non-zero address.
    assign wr1_en = we1 && !busy && !rst && (wa1 != '0);
    assign wr2_en = we2 && !busy && !rst && (wa2 != '0);

    // Next-state logic for the clear sequencer. rst always restarts it from address 0.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        clr_en     = 1'b0;
        if (rst) begin
            state_d    = CLEAR;
            clr_addr_d = '0;
        end else begin
            case (state_q)
                CLEAR: begin
                    clr_en = 1'b1;
                    if (clr_addr_q == LAST_ADDR) begin
                        // Hold the counter at the last address; it does not wrap.
                        state_d = READY;
                    end else begin
                        clr_addr_d = clr_addr_q + ADDR_W'(1'b1);
                    end
                end
                READY: begin
                    state_d = READY;
                end
                default: begin
                    state_d    = CLEAR;
                    clr_addr_d = '0;
                end
            endcase
        end
    end

    // State register for the sequencer. Reset affects only control state.
    always_ff @(posedge clk) begin
        state_q    <= state_d;
        clr_addr_q <= clr_addr_d;
    end

    // Next array contents. Clearing and user writes never overlap.
    // Port 2 is applied last, so it wins when both ports write the same address.
    always_comb begin
        mem_d = mem_q;
        if (clr_en) begin
            mem_d[clr_addr_q] = '0;
        end
        if (wr1_en) begin
            mem_d[wa1] = wd1;
        end
        if (wr2_en) begin
            mem_d[wa2] = wd2;
        end
    end

    // Array storage. It is never reset directly; only the CLEAR sequence zeroes it.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Combinational read ports, with optional write-through bypass.
    // busy and address 0 force the output to zero in both builds.
    always_comb begin
        ra_v[0] = ra1;
        ra_v[1] = ra2;
        ra_v[2] = ra3;
        for (int p = 0; p < 3; p++) begin
            rd_v[p] = mem_q[ra_v[p]];
`ifdef REG_FILE_BYPASS_EN
            if (wr1_en && (wa1 == ra_v[p])) begin
                rd_v[p] = wd1;
            end
            if (wr2_en && (wa2 == ra_v[p])) begin
                rd_v[p] = wd2;
            end
`endif
            if (busy || (ra_v[p] == '0)) begin
                rd_v[p] = '0;
            end
        end
    end

    assign rd1 = rd_v[0];
    assign rd2 = rd_v[1];
    assign rd3 = rd_v[2];

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp.
// A behavioural model predicts each cycle's read data and busy flag. The
// prediction is queued when the stimulus is driven and compared at the falling
// edge. Directed checks against fixed constants cover the key scenarios.
module tb_reg_file_mp;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              we1, we2;
    logic [ADDR_W-1:0] wa1, wa2, ra1, ra2, ra3;
    logic [DATA_W-1:0] wd1, wd2, rd1, rd2, rd3;
    logic              busy;

    typedef struct {
        logic [DATA_W-1:0] r1;
        logic [DATA_W-1:0] r2;
        logic [DATA_W-1:0] r3;
        logic              b;
    } exp_t;

    exp_t              sb[$];
    logic [DATA_W-1:0] m_mem [DEPTH];
    bit                m_busy;
    int                m_clr;
    int                n_checks = 0;
    int                n_errors = 0;
    int                cnt;

    always #5 clk = ~clk;

    reg_file_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk  (clk),
        .rst  (rst),
        .we1  (we1),
        .we2  (we2),
        .wa1  (wa1),
        .wa2  (wa2),
        .wd1  (wd1),
        .wd2  (wd2),
        .ra1  (ra1),
        .ra2  (ra2),
        .ra3  (ra3),
        .rd1  (rd1),
        .rd2  (rd2),
        .rd3  (rd3),
        .busy (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] m_read(input logic [ADDR_W-1:0] ra);
        logic [DATA_W-1:0] v;
        v = m_mem[ra];
`ifdef REG_FILE_BYPASS_EN
        if (!rst && !m_busy && we1 && wa1 == ra) v = wd1;
        if (!rst && !m_busy && we2 && wa2 == ra) v = wd2;
`endif
        if (m_busy || ra == 0) v = '0;
        return v;
    endfunction

    task automatic m_update();
        if (rst) begin
            m_busy = 1'b1;
            m_clr  = 0;
        end else if (m_busy) begin
            m_mem[m_clr] = '0;
            if (m_clr == DEPTH - 1) m_busy = 1'b0;
            else m_clr++;
        end else begin
            if (we1 && wa1 != 0) m_mem[wa1] = wd1;
            if (we2 && wa2 != 0) m_mem[wa2] = wd2;
        end
    endtask

    // Run one clock cycle with the inputs currently driven.
    task automatic cycle();
        exp_t e, g;
        e.r1 = m_read(ra1);
        e.r2 = m_read(ra2);
        e.r3 = m_read(ra3);
        e.b  = m_busy;
        sb.push_back(e);
        @(negedge clk);
        g = sb.pop_front();
        chk("sb_rd1", rd1, g.r1);
        chk("sb_rd2", rd2, g.r2);
        chk("sb_rd3", rd3, g.r3);
        chk("sb_busy", {31'b0, busy}, {31'b0, g.b});
        @(posedge clk);
        m_update();
        #1;
    endtask

    task automatic idle();
        we1 = 1'b0; we2 = 1'b0;
        wa1 = '0; wa2 = '0; wd1 = '0; wd2 = '0;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_busy = 1'b1;
        m_clr  = 0;
        idle();
        ra1 = '0; ra2 = '0; ra3 = '0;

        // Hold reset for two cycles.
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        m_busy = 1'b1;
        m_clr  = 0;
        chk("rst_busy", {31'b0, busy}, 32'd1);
        ra1 = 5'd5;
        #1;
        chk("rst_rd_zero", rd1, 32'h0);
        rst = 1'b0;

        // Count the busy cycles after reset is released.
        cnt = 0;
        while (busy && cnt < 100) begin
            ra1 = 5'($urandom_range(0, 31));
            we1 = 1'b1;
            wa1 = 5'd6;
            wd1 = 32'hCAFE0006;
            cycle();
            cnt++;
        end
        idle();
        chk("busy_len", cnt, 32'd32);

        // Registers must read as zero after the clear.
        ra1 = 5'd0; ra2 = 5'd5; ra3 = 5'd31;
        #1;
        chk("clr_rd1_a0", rd1, 32'h0);
        chk("clr_rd2_a5", rd2, 32'h0);
        chk("clr_rd3_a31", rd3, 32'h0);
        ra1 = 5'd6;
        #1;
        chk("busy_write_dropped", rd1, 32'h0);
        cycle();

        // Two writes to different addresses in one cycle.
        we1 = 1'b1; wa1 = 5'd3; wd1 = 32'h11111111;
        we2 = 1'b1; wa2 = 5'd4; wd2 = 32'h22222222;
        cycle();
        idle();
        ra1 = 5'd3; ra2 = 5'd4;
        #1;
        chk("dual_rd1", rd1, 32'h11111111);
        chk("dual_rd2", rd2, 32'h22222222);
        cycle();

        // Both ports write the same address; port 2 must win.
        we1 = 1'b1; wa1 = 5'd7; wd1 = 32'hAAAA0000;
        we2 = 1'b1; wa2 = 5'd7; wd2 = 32'h0000BBBB;
        cycle();
        idle();
        ra3 = 5'd7;
        #1;
        chk("collision_rd3", rd3, 32'h0000BBBB);
        cycle();

        // Writes to address 0 are discarded.
        we1 = 1'b1; wa1 = 5'd0; wd1 = 32'hFFFFFFFF; ra1 = 5'd0;
        #1;
        chk("zero_same", rd1, 32'h0);
        cycle();
        idle();
        #1;
        chk("zero_next", rd1, 32'h0);
        cycle();

        // Read an address in the same cycle it is written.
        we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h12345678; ra1 = 5'd9;
        #1;
`ifdef REG_FILE_BYPASS_EN
        chk("bypass_same", rd1, 32'h12345678);
`else
        chk("bypass_same", rd1, 32'h00000000);
`endif
        cycle();
        idle();
        #1;
        chk("bypass_next", rd1, 32'h12345678);
        cycle();

        // Random traffic, with same-address reads and writes forced now and then.
        for (int i = 0; i < 150; i++) begin
            we1 = 1'($urandom);
            we2 = 1'($urandom);
            wa1 = 5'($urandom);
            wa2 = ($urandom_range(0, 3) == 0) ? wa1 : 5'($urandom);
            wd1 = $urandom;
            wd2 = $urandom;
            ra1 = ($urandom_range(0, 2) == 0) ? wa1 : 5'($urandom);
            ra2 = ($urandom_range(0, 2) == 0) ? wa2 : 5'($urandom);
            ra3 = 5'($urandom);
            cycle();
        end
        idle();

        // Reset in the middle of a clear, with writes attempted while busy.
        we1 = 1'b1; wa1 = 5'd2; wd1 = 32'hDEADBEEF;
        cycle();
        idle();
        ra1 = 5'd2;
        #1;
        chk("pre_mid_addr2", rd1, 32'hDEADBEEF);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cnt = 0;
        while (m_clr != 10 && cnt < 50) begin
            we1 = 1'b1; wa1 = 5'd2; wd1 = $urandom;
            cycle();
            cnt++;
        end
        chk("mid_reach_10", cnt, 32'd10);
        rst = 1'b1;
        we1 = 1'b1; wa1 = 5'd2; wd1 = 32'h5A5A5A5A;
        cycle();
        rst = 1'b0;
        cnt = 0;
        while (busy && cnt < 100) begin
            we1 = 1'b1; wa1 = 5'd2; wd1 = $urandom;
            we2 = 1'b1; wa2 = 5'($urandom_range(1, 31)); wd2 = $urandom;
            cycle();
            cnt++;
        end
        idle();
        chk("mid_busy_len", cnt, 32'd32);
        ra1 = 5'd2; ra2 = 5'd3; ra3 = 5'd31;
        #1;
        chk("mid_addr2_zero", rd1, 32'h0);
        chk("mid_addr3_zero", rd2, 32'h0);
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
